// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states and grant owner.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational owner pick: load/store wins ties unless instruction fetch has waited
// through a full streak of load/store grants. Also produces the next streak value.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_LS_STREAK = 4,
    parameter int STREAK_W      = $clog2(MAX_LS_STREAK + 1)
) (
    input  logic                i_if_req,
    input  logic                i_ls_req,
    input  logic [STREAK_W-1:0] i_streak,
    output owner_e              o_owner,
    output logic [STREAK_W-1:0] o_streak_next
);

    logic w_streak_full;

    assign w_streak_full = (i_streak == STREAK_W'(MAX_LS_STREAK));

    always_comb begin
        o_owner       = OWN_NONE;
        o_streak_next = i_streak;
        if (i_ls_req && !(i_if_req && w_streak_full)) begin
            o_owner = OWN_LS;
            // The streak only counts LS grants that actually made a fetch wait.
            if (i_if_req) begin
                o_streak_next = w_streak_full ? i_streak : i_streak + STREAK_W'(1);
            end else begin
                o_streak_next = '0;
            end
        end else if (i_if_req) begin
            o_owner       = OWN_IF;
            o_streak_next = '0;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one unified memory port between instruction fetch and load/store using an
// IDLE -> ACCESS -> RESP handshake with registered address/data toward memory.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 1,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_ack_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_ack_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int               CNT_W    = $clog2(ACCESS_CYCLES) + 1;
    localparam int               STREAK_W = $clog2(MAX_LS_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]            r_state;
    owner_e                r_owner;
    logic [CNT_W-1:0]      r_cnt;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic                  r_if_ack;
    logic                  r_ls_ack;

    owner_e                w_owner_sel;
    logic [STREAK_W-1:0]   w_streak_next;
    logic                  w_last;
    logic                  w_store;

    mem_arb_select #(
        .MAX_LS_STREAK (MAX_LS_STREAK),
        .STREAK_W      (STREAK_W)
    ) u_select (
        .i_if_req      (if_req_i),
        .i_ls_req      (ls_req_i),
        .i_streak      (r_streak),
        .o_owner       (w_owner_sel),
        .o_streak_next (w_streak_next)
    );

    assign w_last  = (r_state == ST_ACCESS) && (r_cnt == '0);
    assign w_store = w_last && (r_owner == OWN_LS) && r_we;

    // Gated by reset so a store caught in its final cycle by reset never reaches memory.
    assign mem_we_o    = w_store && !reset;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign if_ack_o    = r_if_ack;
    assign if_rdata_o  = r_if_rdata;
    assign ls_ack_o    = r_ls_ack;
    assign ls_rdata_o  = r_ls_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_NONE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_owner_sel != OWN_NONE) begin
                        r_owner  <= w_owner_sel;
                        r_streak <= w_streak_next;
                        r_cnt    <= CNT_LOAD;
                        r_state  <= ST_ACCESS;
                        if (w_owner_sel == OWN_LS) begin
                            r_mem_addr  <= ls_addr_i;
                            r_mem_wdata <= ls_wdata_i;
                            r_we        <= ls_we_i;
                        end else begin
                            r_mem_addr <= if_addr_i;
                            r_we       <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Read data is valid in the last held cycle; stores keep the old load data.
                        if (r_owner == OWN_LS) begin
                            if (!r_we) begin
                                r_ls_rdata <= mem_rdata_i;
                            end
                            r_ls_ack <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata_i;
                            r_if_ack   <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: two instances (1 and 3 access cycles), directed cases
// plus random traffic against a transaction-level reference model.
module tb_mem_access_arbiter;

    localparam int DW   = 32;
    localparam int NI   = 2;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req   [NI];
    logic [DW-1:0] if_addr  [NI];
    logic          if_ack   [NI];
    logic [DW-1:0] if_rdata [NI];
    logic          ls_req   [NI];
    logic          ls_we    [NI];
    logic [DW-1:0] ls_addr  [NI];
    logic [DW-1:0] ls_wdata [NI];
    logic          ls_ack   [NI];
    logic [DW-1:0] ls_rdata [NI];
    logic          mem_we   [NI];
    logic [DW-1:0] mem_addr [NI];
    logic [DW-1:0] mem_wdata[NI];
    logic [DW-1:0] mem_rdata[NI];

    int n_cmp = 0;
    int n_mis = 0;

    // Memory contents: one fixed word for the fetch case, an address hash elsewhere.
    function automatic logic [DW-1:0] mem_model(input logic [DW-1:0] a);
        if (a == 32'h0040_0004) return 32'h2008_0005;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int ac_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            mem_access_arbiter #(
                .DATA_WIDTH    (DW),
                .ACCESS_CYCLES (gi == 0 ? 1 : 3),
                .MAX_LS_STREAK (MAXS)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .if_req_i    (if_req[gi]),
                .if_addr_i   (if_addr[gi]),
                .if_ack_o    (if_ack[gi]),
                .if_rdata_o  (if_rdata[gi]),
                .ls_req_i    (ls_req[gi]),
                .ls_we_i     (ls_we[gi]),
                .ls_addr_i   (ls_addr[gi]),
                .ls_wdata_i  (ls_wdata[gi]),
                .ls_ack_o    (ls_ack[gi]),
                .ls_rdata_o  (ls_rdata[gi]),
                .mem_we_o    (mem_we[gi]),
                .mem_addr_o  (mem_addr[gi]),
                .mem_wdata_o (mem_wdata[gi]),
                .mem_rdata_i (mem_rdata[gi])
            );
            assign mem_rdata[gi] = mem_model(mem_addr[gi]);
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NI; k++) begin
            if_req[k]   = 1'b0;
            if_addr[k]  = '0;
            ls_req[k]   = 1'b0;
            ls_we[k]    = 1'b0;
            ls_addr[k]  = '0;
            ls_wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic check_zero(input int k, input string tag);
        check_eq($sformatf("k%0d %s if_ack", k, tag), if_ack[k], 0);
        check_eq($sformatf("k%0d %s if_rdata", k, tag), if_rdata[k], 0);
        check_eq($sformatf("k%0d %s ls_ack", k, tag), ls_ack[k], 0);
        check_eq($sformatf("k%0d %s ls_rdata", k, tag), ls_rdata[k], 0);
        check_eq($sformatf("k%0d %s mem_we", k, tag), mem_we[k], 0);
        check_eq($sformatf("k%0d %s mem_addr", k, tag), mem_addr[k], 0);
        check_eq($sformatf("k%0d %s mem_wdata", k, tag), mem_wdata[k], 0);
    endtask

    // Complete one LS transaction, waiting a bounded number of cycles for the ack.
    task automatic ls_xact(input int k, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        ls_req[k] = 1'b1; ls_we[k] = we; ls_addr[k] = a; ls_wdata[k] = d;
        @(negedge clk);
        while (ls_ack[k] !== 1'b1 && waited < 20) begin
            next_cycle();
            @(negedge clk);
            waited++;
        end
        check_eq($sformatf("k%0d ls_xact ack", k), ls_ack[k], 1);
        next_cycle();
        ls_req[k] = 1'b0;
    endtask

    task automatic test_single_if(input int k);
        do_reset();
        if_req[k] = 1'b1; if_addr[k] = 32'h0040_0004;
        @(negedge clk);
        check_eq("if N ack", if_ack[k], 0);
        next_cycle(); @(negedge clk);
        check_eq("if N+1 mem_addr", mem_addr[k], 32'h0040_0004);
        check_eq("if N+1 mem_we", mem_we[k], 0);
        check_eq("if N+1 ack", if_ack[k], 0);
        next_cycle(); @(negedge clk);
        check_eq("if N+2 ack", if_ack[k], 1);
        check_eq("if N+2 rdata", if_rdata[k], 32'h2008_0005);
        check_eq("if N+2 mem_we", mem_we[k], 0);
        next_cycle();
        if_req[k] = 1'b0;
        @(negedge clk);
        check_eq("if N+3 ack", if_ack[k], 0);
        check_eq("if N+3 rdata hold", if_rdata[k], 32'h2008_0005);
    endtask

    task automatic test_single_store(input int k);
        do_reset();
        ls_xact(k, 1'b0, 32'h1001_0100, '0);
        ls_req[k] = 1'b1; ls_we[k] = 1'b1; ls_addr[k] = 32'h1001_0008; ls_wdata[k] = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("st N mem_we", mem_we[k], 0);
        next_cycle(); @(negedge clk);
        check_eq("st N+1 mem_we", mem_we[k], 1);
        check_eq("st N+1 mem_addr", mem_addr[k], 32'h1001_0008);
        check_eq("st N+1 mem_wdata", mem_wdata[k], 32'hDEAD_BEEF);
        check_eq("st N+1 ack", ls_ack[k], 0);
        next_cycle(); @(negedge clk);
        check_eq("st N+2 mem_we", mem_we[k], 0);
        check_eq("st N+2 ack", ls_ack[k], 1);
        check_eq("st N+2 rdata kept", ls_rdata[k], mem_model(32'h1001_0100));
        next_cycle();
        ls_req[k] = 1'b0;
        @(negedge clk);
        check_eq("st N+3 ack", ls_ack[k], 0);
        check_eq("st N+3 mem_we", mem_we[k], 0);
    endtask

    task automatic test_load_ac3(input int k);
        do_reset();
        ls_req[k] = 1'b1; ls_we[k] = 1'b0; ls_addr[k] = 32'h1001_0040;
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); @(negedge clk);
            check_eq($sformatf("ld3 N+%0d mem_addr", c), mem_addr[k], 32'h1001_0040);
            check_eq($sformatf("ld3 N+%0d ack", c), ls_ack[k], 0);
            check_eq($sformatf("ld3 N+%0d mem_we", c), mem_we[k], 0);
        end
        next_cycle(); @(negedge clk);
        check_eq("ld3 N+4 ack", ls_ack[k], 1);
        check_eq("ld3 N+4 rdata", ls_rdata[k], mem_model(32'h1001_0040));
        next_cycle();
        ls_req[k] = 1'b0;
    endtask

    task automatic test_reset_store(input int k);
        do_reset();
        ls_req[k] = 1'b1; ls_we[k] = 1'b1; ls_addr[k] = 32'h1001_0010; ls_wdata[k] = 32'hCAFE_F00D;
        next_cycle(); next_cycle(); @(negedge clk);
        check_eq("rst_st N+2 mem_we", mem_we[k], 0);
        next_cycle();
        reset = 1'b1; ls_req[k] = 1'b0;
        @(negedge clk);
        check_eq("rst_st last mem_we", mem_we[k], 0);
        check_eq("rst_st last mem_addr", mem_addr[k], 32'h1001_0010);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_zero(k, "rst_st after");
        next_cycle(); @(negedge clk);
        check_eq("rst_st later ack", ls_ack[k], 0);
        check_eq("rst_st later mem_we", mem_we[k], 0);
    endtask

    task automatic test_drop_mid(input int k);
        do_reset();
        ls_req[k] = 1'b1; ls_we[k] = 1'b0; ls_addr[k] = 32'h1001_0020;
        next_cycle();
        ls_req[k] = 1'b0; ls_we[k] = 1'b1; ls_addr[k] = 32'h1001_0FF0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("drop N+%0d mem_addr", c), mem_addr[k], 32'h1001_0020);
            check_eq($sformatf("drop N+%0d mem_we", c), mem_we[k], 0);
            next_cycle();
        end
        @(negedge clk);
        check_eq("drop N+4 ack", ls_ack[k], 1);
        check_eq("drop N+4 rdata", ls_rdata[k], mem_model(32'h1001_0020));
        next_cycle(); @(negedge clk);
        check_eq("drop N+5 ack", ls_ack[k], 0);
    endtask

    // Both requesters always asking: every fifth grant must go to instruction fetch.
    task automatic test_priority(input int k);
        logic rec_ls [10];
        int   got = 0;
        do_reset();
        if_req[k] = 1'b1; if_addr[k] = 32'h0040_0100;
        ls_req[k] = 1'b1; ls_we[k] = 1'b0; ls_addr[k] = 32'h1001_0200;
        for (int c = 0; c < 200 && got < 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("k%0d prio ack_excl", k), if_ack[k] & ls_ack[k], 0);
            if (if_ack[k] || ls_ack[k]) begin
                rec_ls[got] = ls_ack[k];
                got++;
            end
            next_cycle();
        end
        check_eq($sformatf("k%0d prio grant count", k), got, 10);
        for (int i = 0; i < got; i++) begin
            check_eq($sformatf("k%0d prio grant %0d is_ls", k, i), rec_ls[i], (i % 5 == 4) ? 0 : 1);
        end
        idle_inputs();
    endtask

    // Random traffic against a transaction model: a grant is decided when the arbiter is free,
    // the ack lands ACCESS_CYCLES+1 cycles later, and the next grant one cycle after the ack.
    task automatic run_random(input int k, input int ncyc, input int raise_pct);
        int            ac = ac_of(k);
        bit            g_busy = 0, g_is_ls = 0, g_we = 0;
        logic [DW-1:0] g_addr = '0, g_wdata = '0;
        int            g_cyc = 0, ack_cyc = 0, next_free = 0, streak = 0, n_tx = 0;
        logic [DW-1:0] e_if_rd = '0, e_ls_rd = '0;
        bit            if_done = 0, ls_done = 0, pick_ls, e_if_ack, e_ls_ack, e_we;
        do_reset();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (if_done) if_req[k] = 1'b0;
            if (ls_done) ls_req[k] = 1'b0;
            if (!if_req[k] && $urandom_range(99) < raise_pct) begin
                if_req[k] = 1'b1; if_addr[k] = $urandom;
            end
            if (!ls_req[k] && $urandom_range(99) < raise_pct) begin
                ls_req[k] = 1'b1; ls_we[k] = 1'($urandom_range(1));
                ls_addr[k] = $urandom; ls_wdata[k] = $urandom;
            end
            if (g_busy && cyc > g_cyc && $urandom_range(1) == 1) begin
                if (g_is_ls) begin
                    ls_addr[k] = $urandom; ls_wdata[k] = $urandom; ls_we[k] = ~ls_we[k];
                end else begin
                    if_addr[k] = $urandom;
                end
            end
            if_done = 0; ls_done = 0;
            @(negedge clk);
            e_if_ack = g_busy && !g_is_ls && cyc == ack_cyc;
            e_ls_ack = g_busy && g_is_ls && cyc == ack_cyc;
            e_we     = g_busy && g_is_ls && g_we && cyc == ack_cyc - 1;
            if (e_if_ack) e_if_rd = mem_model(g_addr);
            if (e_ls_ack && !g_we) e_ls_rd = mem_model(g_addr);
            check_eq($sformatf("k%0d c%0d if_ack", k, cyc), if_ack[k], e_if_ack);
            check_eq($sformatf("k%0d c%0d ls_ack", k, cyc), ls_ack[k], e_ls_ack);
            check_eq($sformatf("k%0d c%0d mem_we", k, cyc), mem_we[k], e_we);
            check_eq($sformatf("k%0d c%0d if_rdata", k, cyc), if_rdata[k], e_if_rd);
            check_eq($sformatf("k%0d c%0d ls_rdata", k, cyc), ls_rdata[k], e_ls_rd);
            if (g_busy && cyc > g_cyc && cyc < ack_cyc)
                check_eq($sformatf("k%0d c%0d mem_addr", k, cyc), mem_addr[k], g_addr);
            if (e_we)
                check_eq($sformatf("k%0d c%0d mem_wdata", k, cyc), mem_wdata[k], g_wdata);
            if (e_if_ack) begin if_done = 1; g_busy = 0; end
            if (e_ls_ack) begin ls_done = 1; g_busy = 0; end
            if (cyc >= next_free && (if_req[k] || ls_req[k])) begin
                pick_ls = ls_req[k] && !(if_req[k] && streak == MAXS);
                if (pick_ls) begin
                    streak  = if_req[k] ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
                    g_addr  = ls_addr[k]; g_wdata = ls_wdata[k]; g_we = ls_we[k];
                end else begin
                    streak = 0;
                    g_addr = if_addr[k]; g_we = 1'b0;
                end
                g_is_ls   = pick_ls;
                g_busy    = 1;
                g_cyc     = cyc;
                ack_cyc   = cyc + ac + 1;
                next_free = ack_cyc + 1;
                n_tx++;
            end
            next_cycle();
        end
        $display("random k%0d: %0d cycles, %0d grants", k, ncyc, n_tx);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < NI; k++) check_zero(k, "reset");
        test_single_if(0);
        test_single_store(0);
        test_priority(0);
        test_load_ac3(1);
        test_reset_store(1);
        test_drop_mid(1);
        test_priority(1);
        run_random(0, 3000, 40);
        run_random(0, 1500, 95);
        run_random(1, 3000, 40);
        run_random(1, 1500, 95);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
